// File: rtl/serial_word_feeder_msb_first.sv
// Purpose: serializes a W-bit word MSB first onto a valid/ready bit stream, tagging first/last bits.
// Latency: first bit valid the cycle after word acceptance; W bit cycles per word, back-to-back words without a bubble.
// Backpressure: bit_ready low holds bit, tags and state; a new word is taken only alongside the last bit transfer.
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   in_valid / in_ready / in_data  parallel word input handshake (in_data[W-1] leaves first)
//   bit_valid / bit_ready          serial bit output handshake
//   new_bit, first_bit, last_bit   current bit and word-boundary tags
//   busy                           a word is being shifted out
module serial_word_feeder_msb_first #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         bit_valid,
  input  logic         bit_ready,
  output logic         new_bit,
  output logic         first_bit,
  output logic         last_bit,
  output logic         busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic word_xfer;
  logic bit_xfer;

  // Output decodes come straight from registered state.
  always_comb begin
    bit_valid = 1'b0;
    new_bit   = 1'b0;
    first_bit = 1'b0;
    last_bit  = 1'b0;
    if (state_q == SHIFT) begin
      bit_valid = 1'b1;
      new_bit   = sr_q[W-1];
      first_bit = (cnt_q == CNT_MAX);
      last_bit  = (cnt_q == '0);
    end
  end

  assign busy = (state_q == SHIFT);

  // Accepting during the final bit transfer is what removes the bubble
  // between words; this makes in_ready combinational on bit_ready.
  assign in_ready = !rst && ((state_q == IDLE) ||
                             ((state_q == SHIFT) && last_bit && bit_ready));

  assign word_xfer = in_valid && in_ready;
  assign bit_xfer  = bit_valid && bit_ready;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (word_xfer) begin
          sr_d    = in_data;
          cnt_d   = CNT_MAX;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_xfer) begin
          if (!last_bit) begin
            sr_d  = sr_q << 1;
            cnt_d = cnt_q - 1'b1;
          end else if (word_xfer) begin
            sr_d  = in_data;
            cnt_d = CNT_MAX;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
